// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture path: FSM encoding,
// default frame geometry and the RGB565 -> RGB444 pixel reduction.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_FRAME   = 2'd2,
        ST_LINE    = 2'd3
    } cam_state_t;

    localparam int H_ACTIVE_DEF = 320;
    localparam int V_ACTIVE_DEF = 240;

    // Keep the top nibble of each channel; G6 straddles the byte boundary.
    function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

endpackage

// File: rtl/cam_byte_pair.sv
// Byte-pair assembler: alternates hi/lo byte phase, latches the high byte and
// flags the cycle in which a complete RGB565 pixel is present.
module cam_byte_pair (
    input  logic       pclk,
    input  logic       nreset,
    input  logic       clear,
    input  logic       byte_vld,
    input  logic [7:0] byte_in,
    output logic       phase,
    output logic [7:0] byte_hi,
    output logic       pix_vld
);

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            phase   <= 1'b0;
            byte_hi <= 8'h00;
        end else if (byte_vld) begin
            phase <= ~phase;
            if (!phase) byte_hi <= byte_in;
        end else if (clear) begin
            phase <= 1'b0;
        end
    end

    assign pix_vld = byte_vld & phase;

endmodule

// File: rtl/cam_capture.sv
// Camera frame grabber: tracks VSYNC/HREF framing of an 8-bit RGB565 stream
// and emits RGB444 frame-buffer writes with per-frame error status.
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = 17
) (
    input  logic              pclk,
    input  logic              nreset,
    input  logic              enable,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        pdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    // pix_cnt saturates at H_ACTIVE+1 so over-long lines stay distinguishable.
    localparam int PW = $clog2(H_ACTIVE + 2);
    localparam int LW = $clog2(V_ACTIVE + 1);

    cam_state_t state, state_nxt;

    logic              vsync_r, vsync_d, href_r, href_d;
    logic [7:0]        pdata_r;
    logic [PW-1:0]     pix_cnt;
    logic [LW-1:0]     line_cnt;
    logic [ADDR_W-1:0] line_base;
    logic              err_acc;

    logic vs_rise, vs_fall, hr_rise, hr_fall;
    logic start_frame, end_frame, go_line, end_line, line_over;
    logic byte_vld, pair_clr, phase, pix_vld;
    logic [7:0] byte_hi;

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            vsync_r <= 1'b0;
            vsync_d <= 1'b0;
            href_r  <= 1'b0;
            href_d  <= 1'b0;
            pdata_r <= 8'h00;
        end else begin
            vsync_r <= vsync;
            vsync_d <= vsync_r;
            href_r  <= href;
            href_d  <= href_r;
            pdata_r <= pdata;
        end
    end

    assign vs_rise = vsync_r & ~vsync_d;
    assign vs_fall = ~vsync_r & vsync_d;
    assign hr_rise = href_r & ~href_d;
    assign hr_fall = ~href_r & href_d;

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        go_line     = 1'b0;
        end_line    = 1'b0;
        line_over   = 1'b0;
        case (state)
            ST_IDLE:    if (enable) state_nxt = ST_WAIT_VS;
            ST_WAIT_VS: if (vs_fall) begin
                state_nxt   = ST_FRAME;
                start_frame = 1'b1;
            end
            ST_FRAME: begin
                if (vs_rise) begin
                    end_frame = 1'b1;
                    state_nxt = enable ? ST_WAIT_VS : ST_IDLE;
                end else if (hr_rise) begin
                    if (line_cnt < LW'(V_ACTIVE)) begin
                        go_line   = 1'b1;
                        state_nxt = ST_LINE;
                    end else begin
                        line_over = 1'b1;
                    end
                end
            end
            ST_LINE: begin
                // VSYNC wins over any line activity: the line is abandoned.
                if (vs_rise) begin
                    end_frame = 1'b1;
                    state_nxt = enable ? ST_WAIT_VS : ST_IDLE;
                end else if (hr_fall) begin
                    end_line  = 1'b1;
                    state_nxt = ST_FRAME;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The HREF rising cycle already carries the first (phase 0) byte.
    assign byte_vld = href_r & (go_line | ((state == ST_LINE) & ~vs_rise));
    assign pair_clr = (state != ST_LINE) | end_line | end_frame;
    assign busy     = (state == ST_FRAME) | (state == ST_LINE);

    cam_byte_pair u_pair (
        .pclk     (pclk),
        .nreset   (nreset),
        .clear    (pair_clr),
        .byte_vld (byte_vld),
        .byte_in  (pdata_r),
        .phase    (phase),
        .byte_hi  (byte_hi),
        .pix_vld  (pix_vld)
    );

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 12'h000;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            line_base   <= '0;
            err_acc     <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            frame_start <= start_frame;
            frame_done  <= end_frame;
            if (start_frame) begin
                pix_cnt   <= '0;
                line_cnt  <= '0;
                line_base <= '0;
                wr_addr   <= '0;
                err_acc   <= 1'b0;
            end
            if (pix_vld) begin
                if (pix_cnt < PW'(H_ACTIVE)) begin
                    wr_en   <= 1'b1;
                    wr_addr <= line_base + ADDR_W'(pix_cnt);
                    wr_data <= rgb565_to_444(byte_hi, pdata_r);
                end
                if (pix_cnt != PW'(H_ACTIVE + 1)) pix_cnt <= pix_cnt + 1'b1;
            end
            if (line_over) err_acc <= 1'b1;
            if (end_line) begin
                line_cnt  <= line_cnt + 1'b1;
                line_base <= line_base + ADDR_W'(H_ACTIVE);
                pix_cnt   <= '0;
                if ((pix_cnt != PW'(H_ACTIVE)) || phase) err_acc <= 1'b1;
            end
            if (end_frame) begin
                frame_err <= err_acc | (line_cnt != LW'(V_ACTIVE));
                err_acc   <= 1'b0;
                pix_cnt   <= '0;
            end
        end
    end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter H_ACTIVE, default 320: pixels per captured line.
REQ-002 Parameter V_ACTIVE, default 240: lines per captured frame.
REQ-003 Parameter ADDR_W, default 17: frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
REQ-004 pclk  in  1  sole clock, camera pixel clock; all logic on rising edge.
REQ-005 nreset  in  1  reset, asynchronous assert, active-low.
REQ-006 enable  in  1  arm capture; sampled only at frame boundaries.
REQ-007 vsync  in  1  camera VSYNC, high during vertical blanking.
REQ-008 href  in  1  camera HREF, high while line bytes are valid.
REQ-009 pdata  in  8  camera byte, RGB565, high byte first.
REQ-010 wr_en  out  1  one-cycle frame-buffer write strobe.
REQ-011 wr_addr  out  ADDR_W  write address, line*H_ACTIVE+pixel.
REQ-012 wr_data  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-013 frame_start  out  1  one-cycle pulse when a captured frame begins.
REQ-014 frame_done  out  1  one-cycle pulse when a captured frame ends.
REQ-015 frame_err  out  1  status of last frame, valid from frame_done until next frame_done.
REQ-016 busy  out  1  high in states FRAME and LINE.

Function
REQ-017 vsync, href, pdata SHALL be registered once (vsync_r, href_r, pdata_r); all decisions use registered values; vsync_r additionally delayed once for edge detection.
REQ-018 FSM states SHALL be IDLE, WAIT_VS, FRAME, LINE.
REQ-019 IDLE -> WAIT_VS when enable=1; WAIT_VS waits for vsync falling edge -> FRAME, frame_start pulses that cycle, pixel/line counters and wr_addr cleared.
REQ-020 FRAME -> LINE on href_r rising while line count < V_ACTIVE; line starts with byte phase 0.
REQ-021 In LINE, each href_r=1 cycle SHALL toggle byte phase; phase 0 stores byte_hi=pdata_r; phase 1 forms pixel.
REQ-022 Pixel conversion: R5=byte_hi[7:3], G6={byte_hi[2:0],pdata_r[7:5]}, B5=pdata_r[4:0]; wr_data={R5[4:1],G6[5:2],B5[4:1]}.
REQ-023 wr_en SHALL assert the cycle after phase-1 sampling (two pclk cycles after the second byte is at the pins) only when pixel count < H_ACTIVE; wr_addr increments by 1 after each write.
REQ-024 LINE -> FRAME on href_r falling; line count increments; line's pixel count reset.
REQ-025 Line with pixel count != H_ACTIVE, odd byte count (dangling byte dropped), or href_r rising once line count = V_ACTIVE (line ignored, no writes) SHALL set frame_err_acc.
REQ-026 On vsync rising edge in FRAME or LINE: frame_done pulses; frame_err = frame_err_acc OR (line count != V_ACTIVE); next state WAIT_VS if enable=1 else IDLE; accumulator cleared.
REQ-027 vsync rising while in LINE SHALL abort the line (partial pixel not written).
REQ-028 enable deasserted mid-frame SHALL NOT stop the current frame.
REQ-029 frame_start and frame_done SHALL never assert in the same cycle.

Reset
REQ-030 On nreset=0: state IDLE; wr_en, frame_start, frame_done, frame_err, busy = 0; wr_addr, wr_data, counters, phase, input registers = 0.
REQ-031 Reset mid-frame SHALL discard the frame; capture restarts only after a fresh vsync falling edge.

Structure
REQ-032 Package cam_pkg SHALL hold state encoding, H_ACTIVE/V_ACTIVE defaults and the RGB565-to-RGB444 conversion function.
REQ-033 Sub-module cam_byte_pair SHALL implement phase toggle, byte_hi latch and pixel-valid generation.

Verification
REQ-034 enable=1, one 320x240 frame, byte pairs 0xF8,0x00 -> 76800 writes, addr 0..76799, wr_data 0xF00, frame_done with frame_err=0.
REQ-035 Pair 0x07,0xE0 -> wr_data 0x0F0; pair 0x00,0x1F -> 0x00F; write 2 cycles after second byte.
REQ-036 Line of 641 bytes -> 320 writes, byte 641 dropped, frame_err=1 at frame_done.
REQ-037 241 lines -> line 241 produces no writes, last wr_addr 76799, frame_err=1.
REQ-038 nreset low at line 100, released mid-frame -> no writes until next vsync fall, then frame_start and wr_addr from 0.
REQ-039 enable dropped at line 50 -> frame completes, frame_done pulses, state IDLE, no frame_start at next vsync fall.
